// File: rtl/uart_b_core.sv
// uart_b_core -- UART transmitter/receiver core with single-byte or 4-byte burst TX.
//
// Ports:
//   clk     in   1  single clock, all state on rising edge
//   rst     in   1  asynchronous active-high reset
//   d       in  32  write data: TX byte d[7:0] / burst word d[31:0], divider d[8:0], mode d[9]
//   wrtx    in   1  one-cycle TX write strobe (accepted only while thre=1)
//   wrbaud  in   1  one-cycle divider/mode write strobe
//   rxd     in   1  serial receive line, idle high, asynchronous to clk
//   rd      in   1  one-cycle RX read strobe, clears dv and ovf
//   txd     out  1  serial transmit line, idle high
//   q       out  8  last received byte
//   dv      out  1  received data valid
//   fe      out  1  framing error of the last received byte
//   ovf     out  1  RX overrun
//   thre    out  1  TX holding register empty
//   tend    out  1  transmitter fully idle
//
// One bit time is divider+1 clk cycles for both directions. Frames are
// 1 start bit, 8 data bits LSB first, 1 stop bit.
module uart_b_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d,
  input  logic        wrtx,
  input  logic        wrbaud,
  input  logic        rxd,
  input  logic        rd,
  output logic        txd,
  output logic [7:0]  q,
  output logic        dv,
  output logic        fe,
  output logic        ovf,
  output logic        thre,
  output logic        tend
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  logic [8:0]  divider_q;
  logic        mode_q;

  txState_t    txState_q;
  logic        txd_q;
  logic        thre_q;
  logic [31:0] hold_q;
  logic [2:0]  holdCnt_q;
  logic [31:0] txWord_q;
  logic [2:0]  txLeft_q;
  logic [2:0]  txBit_q;
  logic [8:0]  txCnt_q;
  logic [8:0]  txDiv_q;

  rxState_t    rxState_q;
  logic        rxS1_q;
  logic        rxS2_q;
  logic        rxPrev_q;
  logic [9:0]  rxCnt_q;
  logic [8:0]  rxDiv_q;
  logic [2:0]  rxBit_q;
  logic [7:0]  rxShift_q;
  logic [7:0]  q_q;
  logic        dv_q;
  logic        fe_q;
  logic        ovf_q;

  logic [9:0]  rxBitLen;
  logic [9:0]  rxHalf;
  logic        rxFall;

  // Bit length and half-bit point of the frame being received; the divider
  // is captured at each sample so a change lands on a bit boundary.
  assign rxBitLen = {1'b0, rxDiv_q} + 10'd1;
  assign rxHalf   = rxBitLen >> 1;
  assign rxFall   = rxPrev_q & ~rxS2_q;

  assign txd  = txd_q;
  assign thre = thre_q;
  assign tend = (txState_q == TX_IDLE) && thre_q;
  assign q    = q_q;
  assign dv   = dv_q;
  assign fe   = fe_q;
  assign ovf  = ovf_q;

  // Divider and mode registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divider_q <= 9'd0;
      mode_q    <= 1'b0;
    end else if (wrbaud) begin
      divider_q <= d[8:0];
      mode_q    <= d[9];
    end
  end

  // Transmitter: holding register plus shifter FSM. The mode is sampled
  // with the write, so later mode changes never touch a latched word.
  // Each bit re-reads the divider at its boundary, and burst frames chain
  // from stop bit straight into the next start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txState_q <= TX_IDLE;
      txd_q     <= 1'b1;
      thre_q    <= 1'b1;
      hold_q    <= 32'd0;
      holdCnt_q <= 3'd0;
      txWord_q  <= 32'd0;
      txLeft_q  <= 3'd0;
      txBit_q   <= 3'd0;
      txCnt_q   <= 9'd0;
      txDiv_q   <= 9'd0;
    end else begin
      if (wrtx && thre_q) begin
        hold_q    <= mode_q ? d : {24'd0, d[7:0]};
        holdCnt_q <= mode_q ? 3'd4 : 3'd1;
        thre_q    <= 1'b0;
      end
      if (txState_q == TX_IDLE) begin
        if (!thre_q) begin
          txWord_q  <= hold_q;
          txLeft_q  <= holdCnt_q;
          thre_q    <= 1'b1;
          txState_q <= TX_START;
          txd_q     <= 1'b0;
          txCnt_q   <= 9'd0;
          txDiv_q   <= divider_q;
        end
      end else if (txCnt_q != txDiv_q) begin
        txCnt_q <= txCnt_q + 9'd1;
      end else begin
        txCnt_q <= 9'd0;
        txDiv_q <= divider_q;
        case (txState_q)
          TX_START: begin
            txState_q <= TX_DATA;
            txBit_q   <= 3'd0;
            txd_q     <= txWord_q[0];
          end
          TX_DATA: begin
            // Eight shifts per frame leave the next burst byte in [7:0].
            txWord_q <= txWord_q >> 1;
            if (txBit_q == 3'd7) begin
              txState_q <= TX_STOP;
              txd_q     <= 1'b1;
            end else begin
              txBit_q <= txBit_q + 3'd1;
              txd_q   <= txWord_q[1];
            end
          end
          TX_STOP: begin
            if (txLeft_q > 3'd1) begin
              txLeft_q  <= txLeft_q - 3'd1;
              txState_q <= TX_START;
              txd_q     <= 1'b0;
            end else begin
              txLeft_q  <= 3'd0;
              txState_q <= TX_IDLE;
            end
          end
          default: txState_q <= TX_IDLE;
        endcase
      end
    end
  end

  // Receiver: two-flop synchronizer, falling-edge start detect, half-bit
  // start qualification, then full-bit steps to each mid-bit sample. With
  // a zero divider the half point is the detect edge itself, so START is
  // skipped. Byte completion is placed after the rd clear so it wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxState_q <= RX_IDLE;
      rxS1_q    <= 1'b1;
      rxS2_q    <= 1'b1;
      rxPrev_q  <= 1'b1;
      rxCnt_q   <= 10'd0;
      rxDiv_q   <= 9'd0;
      rxBit_q   <= 3'd0;
      rxShift_q <= 8'd0;
      q_q       <= 8'd0;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      rxS1_q   <= rxd;
      rxS2_q   <= rxS1_q;
      rxPrev_q <= rxS2_q;
      if (rd) begin
        dv_q  <= 1'b0;
        ovf_q <= 1'b0;
      end
      case (rxState_q)
        RX_IDLE: begin
          if (rxFall) begin
            rxDiv_q   <= divider_q;
            rxCnt_q   <= 10'd1;
            rxBit_q   <= 3'd0;
            rxState_q <= (divider_q == 9'd0) ? RX_DATA : RX_START;
          end
        end
        RX_START: begin
          if (rxCnt_q == rxHalf) begin
            if (rxS2_q) begin
              rxState_q <= RX_IDLE;
            end else begin
              rxState_q <= RX_DATA;
              rxCnt_q   <= 10'd1;
              rxDiv_q   <= divider_q;
            end
          end else begin
            rxCnt_q <= rxCnt_q + 10'd1;
          end
        end
        RX_DATA: begin
          if (rxCnt_q == rxBitLen) begin
            rxCnt_q   <= 10'd1;
            rxDiv_q   <= divider_q;
            rxShift_q <= {rxS2_q, rxShift_q[7:1]};
            rxBit_q   <= rxBit_q + 3'd1;
            if (rxBit_q == 3'd7) rxState_q <= RX_STOP;
          end else begin
            rxCnt_q <= rxCnt_q + 10'd1;
          end
        end
        RX_STOP: begin
          if (rxCnt_q == rxBitLen) begin
            q_q       <= rxShift_q;
            fe_q      <= ~rxS2_q;
            dv_q      <= 1'b1;
            if (dv_q) ovf_q <= 1'b1;
            rxState_q <= RX_IDLE;
          end else begin
            rxCnt_q <= rxCnt_q + 10'd1;
          end
        end
        default: rxState_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_b_core.sv
// tb_uart_b_core -- scoreboard bench for uart_b_core.
//
// A transaction-level model turns accepted writes into expected frames
// (byte value plus the clk cycle its start bit must appear); a monitor
// decodes txd independently and checks RX results as dv rises.
module tb_uart_b_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d;
  logic        wrtx;
  logic        wrbaud;
  logic        rxd;
  logic        rd = 1'b0;
  logic        txd;
  logic [7:0]  q;
  logic        dv;
  logic        fe;
  logic        ovf;
  logic        thre;
  logic        tend;

  logic        rxDrive;
  logic        loopback;
  bit          autoRd;
  bit          manualRd;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] b;
    int         start;
  } txExp_t;

  typedef struct {
    logic [7:0] b;
    logic       fe;
  } rxExp_t;

  txExp_t txQ[$];
  rxExp_t rxQ[$];

  int          cyc = 0;
  bit          mHoldFull;
  logic [31:0] mHold;
  int          mHoldCnt;
  bit          mMode;
  int          mDiv;
  int          mBusyEnd;

  uart_b_core dut (
    .clk    (clk),
    .rst    (rst),
    .d      (d),
    .wrtx   (wrtx),
    .wrbaud (wrbaud),
    .rxd    (rxd),
    .rd     (rd),
    .txd    (txd),
    .q      (q),
    .dv     (dv),
    .fe     (fe),
    .ovf    (ovf),
    .thre   (thre),
    .tend   (tend)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // RX input is either the DUT's own txd or a bench-driven line.
  assign rxd = loopback ? txd : rxDrive;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flagFail(input string name, input string what);
    total++;
    bad++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  // Transaction model, advanced once per rising edge. A word is accepted
  // when the holding slot is empty, moves to the shifter one edge after the
  // previous transmission has ended, and then occupies 10 bit times per
  // byte with frames packed end to end.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mHoldFull = 1'b0;
      mMode     = 1'b0;
      mDiv      = 0;
      mBusyEnd  = 0;
    end else begin
      if (wrtx && !mHoldFull) begin
        mHoldFull = 1'b1;
        mHold     = mMode ? d : {24'd0, d[7:0]};
        mHoldCnt  = mMode ? 4 : 1;
      end else if (mHoldFull && cyc > mBusyEnd) begin
        for (int k = 0; k < mHoldCnt; k++) begin
          txExp_t t;
          rxExp_t r;
          t.b     = mHold[8*k +: 8];
          t.start = cyc + k * 10 * (mDiv + 1);
          txQ.push_back(t);
          if (loopback) begin
            r.b  = t.b;
            r.fe = 1'b0;
            rxQ.push_back(r);
          end
        end
        mBusyEnd  = cyc + mHoldCnt * 10 * (mDiv + 1);
        mHoldFull = 1'b0;
      end
      if (wrbaud) begin
        mDiv  = int'(d[8:0]);
        mMode = d[9];
      end
    end
  end

  // Monitor: on each falling edge compare status flags with the model,
  // decode txd frames at mid-bit and compare with the expected frame
  // queue, and compare each newly valid RX byte with the RX queue.
  initial begin : monitor
    bit         inFrame = 1'b0;
    bit         haveExp = 1'b0;
    bit         dvPrev = 1'b0;
    bit         rdPending = 1'b0;
    int         fStart = 0;
    int         off;
    int         idx;
    int         bt;
    logic [7:0] fByte = 8'd0;
    logic [7:0] expByte = 8'd0;
    txExp_t     t;
    rxExp_t     r;
    forever begin
      @(negedge clk);
      if (rst) begin
        inFrame   = 1'b0;
        dvPrev    = 1'b0;
        rdPending = 1'b0;
        rd        = 1'b0;
        txQ.delete();
        rxQ.delete();
        continue;
      end
      bt = mDiv + 1;
      checkOutput("thre", thre, !mHoldFull);
      checkOutput("tend", tend, (!mHoldFull && cyc >= mBusyEnd));

      if (!inFrame) begin
        if (txd == 1'b0) begin
          inFrame = 1'b1;
          fStart  = cyc;
          fByte   = 8'd0;
          if (txQ.size() == 0) begin
            haveExp = 1'b0;
            flagFail("txUnexpected", $sformatf("start bit at cycle %0d with no frame pending", cyc));
          end else begin
            haveExp = 1'b1;
            t       = txQ.pop_front();
            expByte = t.b;
            checkOutput("txStartCycle", fStart, t.start);
          end
        end
      end else begin
        off = cyc - fStart;
        if (off % bt == bt / 2) begin
          idx = off / bt;
          if (idx == 0) begin
            checkOutput("txStartBit", txd, 1'b0);
          end else if (idx <= 8) begin
            fByte[idx-1] = txd;
          end else begin
            checkOutput("txStopBit", txd, 1'b1);
            if (haveExp) checkOutput("txByte", fByte, expByte);
            inFrame = 1'b0;
          end
        end
      end

      if (rdPending) begin
        rd        = 1'b0;
        rdPending = 1'b0;
        checkOutput("rxDvCleared", dv, 1'b0);
        checkOutput("rxOvfCleared", ovf, 1'b0);
      end else if (dv && !dvPrev) begin
        if (rxQ.size() == 0) begin
          flagFail("rxUnexpected", $sformatf("dv rose with q=%0h and nothing expected", q));
        end else begin
          r = rxQ.pop_front();
          checkOutput("rxByte", q, r.b);
          checkOutput("rxFe", fe, r.fe);
          checkOutput("rxOvf", ovf, 1'b0);
        end
        if (autoRd) begin
          rd        = 1'b1;
          rdPending = 1'b1;
        end
      end else if (manualRd) begin
        manualRd  = 1'b0;
        rd        = 1'b1;
        rdPending = 1'b1;
      end
      dvPrev = dv;
    end
  end

  // Drive strobes for one rising edge, starting from a falling edge.
  task automatic applyStimulus(input logic wrtxV, input logic wrbaudV, input logic [31:0] dV);
    wrtx   = wrtxV;
    wrbaud = wrbaudV;
    d      = dV;
    @(negedge clk);
    wrtx   = 1'b0;
    wrbaud = 1'b0;
  endtask

  // Wait until every expected frame and RX byte has been seen and the
  // model transmitter is idle; a timeout counts as a failure.
  task automatic waitIdle(input int budget);
    int n = 0;
    while (!(txQ.size() == 0 && rxQ.size() == 0 && !mHoldFull && cyc >= mBusyEnd) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) flagFail("waitIdleTimeout", $sformatf("still busy after %0d cycles", budget));
    repeat (4) @(negedge clk);
  endtask

  // Bench-generated serial frame on the RX line.
  task automatic driveRxFrame(input logic [7:0] b, input logic stopBit, input int bt);
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      rxDrive = 1'b0;
      else if (i == 9) rxDrive = stopBit;
      else             rxDrive = b[i-1];
      repeat (bt) @(negedge clk);
    end
    rxDrive = 1'b1;
    repeat (3 * bt) @(negedge clk);
  endtask

  // Directed scenarios followed by randomized traffic in loopback.
  initial begin : stimulus
    logic [31:0] rv;
    int          curDiv;
    rxExp_t      r;
    rst      = 1'b1;
    wrtx     = 1'b0;
    wrbaud   = 1'b0;
    d        = 32'd0;
    rxDrive  = 1'b1;
    loopback = 1'b1;
    autoRd   = 1'b1;
    manualRd = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstTxd", txd, 1'b1);
    checkOutput("rstThre", thre, 1'b1);
    checkOutput("rstTend", tend, 1'b1);
    checkOutput("rstQ", q, 8'h00);
    checkOutput("rstDv", dv, 1'b0);
    checkOutput("rstFe", fe, 1'b0);
    checkOutput("rstOvf", ovf, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single bytes at divider 7, looped back to the receiver.
    applyStimulus(1'b0, 1'b1, 32'h0000_0007);
    applyStimulus(1'b1, 1'b0, 32'h0000_0041);
    waitIdle(2000);
    applyStimulus(1'b1, 1'b0, 32'h0000_0042);
    waitIdle(2000);

    // Burst of four bytes; a mode change mid-burst must not cut it short.
    applyStimulus(1'b0, 1'b1, 32'h0000_0207);
    applyStimulus(1'b1, 1'b0, 32'h4443_4241);
    repeat (100) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'h0000_0007);
    waitIdle(2000);

    // Holding register: B queued behind A, C ignored.
    applyStimulus(1'b1, 1'b0, 32'h0000_0041);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0000_0042);
    checkOutput("threAfterB", thre, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0043);
    waitIdle(3000);

    // Randomized traffic, including writes while full and coinciding
    // wrtx/wrbaud with mode flips.
    for (int rnd = 0; rnd < 3; rnd++) begin
      curDiv = $urandom_range(0, 5);
      rv = 32'd0;
      rv[8:0] = curDiv[8:0];
      applyStimulus(1'b0, 1'b1, rv);
      for (int n = 0; n < 25; n++) begin
        rv = $urandom;
        rv[8:0] = curDiv[8:0];
        applyStimulus(($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0), rv);
        repeat ($urandom_range(0, 15)) @(negedge clk);
      end
      waitIdle(20000);
    end

    // Framing error, a clean frame, then an overrun.
    loopback = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h0000_0007);
    r.b = 8'h5A; r.fe = 1'b1; rxQ.push_back(r);
    driveRxFrame(8'h5A, 1'b0, 8);
    r.b = 8'h33; r.fe = 1'b0; rxQ.push_back(r);
    driveRxFrame(8'h33, 1'b1, 8);
    repeat (4) @(negedge clk);
    autoRd = 1'b0;
    r.b = 8'h11; r.fe = 1'b0; rxQ.push_back(r);
    driveRxFrame(8'h11, 1'b1, 8);
    driveRxFrame(8'h22, 1'b1, 8);
    checkOutput("ovrQ", q, 8'h22);
    checkOutput("ovrOvf", ovf, 1'b1);
    checkOutput("ovrDv", dv, 1'b1);
    manualRd = 1'b1;
    repeat (4) @(negedge clk);
    autoRd = 1'b1;

    // Reset during the second byte of a burst.
    loopback = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h0000_0207);
    applyStimulus(1'b1, 1'b0, 32'hA4A3_A2A1);
    repeat (120) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midRstTxd", txd, 1'b1);
    checkOutput("midRstThre", thre, 1'b1);
    checkOutput("midRstTend", tend, 1'b1);
    checkOutput("midRstQ", q, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    checkOutput("postRstDv", dv, 1'b0);
    waitIdle(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
